display_scan_ctrl: RTL and testbench

//  Time-multiplexed scan controller for the 6-digit seven-segment display. Takes six BCD

---
 rtl/display_pkg.sv | 34 +++
 rtl/display_slot_timer.sv | 39 +++
 rtl/display_scan_ctrl.sv | 120 ++++++++++++
 tb/tb_display_scan_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types and helpers for the six-digit display scan path.
// Digit 0 is the most significant nibble of the BCD word and the MSB of the blink mask.
package display_pkg;

   typedef enum logic [1:0] {IDLE, BLANK, SHOW} scan_state_t;

   localparam logic [3:0] BLANK_CODE = 4'hF;
   localparam int         N_DIGITS   = 6;

   function automatic logic [3:0] digit_nibble(input logic [23:0] d, input logic [2:0] p);
      case (p)
         3'd0:    return d[23:20];
         3'd1:    return d[19:16];
         3'd2:    return d[15:12];
         3'd3:    return d[11:8];
         3'd4:    return d[7:4];
         3'd5:    return d[3:0];
         default: return BLANK_CODE;
      endcase
   endfunction

   function automatic logic mask_bit(input logic [5:0] m, input logic [2:0] p);
      case (p)
         3'd0:    return m[5];
         3'd1:    return m[4];
         3'd2:    return m[3];
         3'd3:    return m[2];
         3'd4:    return m[1];
         3'd5:    return m[0];
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/display_slot_timer.sv
// Slot counter: strobes the last BLANK cycle (show_start) and the last slot cycle (slot_end).
// Latency: strobes are combinational from the counter; counter restarts the cycle after slot_end.
// Backpressure: none; run=0 holds the counter at zero.
module display_slot_timer #(
   parameter int SCAN_DIV  = 50000,
   parameter int BLANK_CYC = 500
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   output logic show_start,
   output logic slot_end
);

   localparam int CW = $clog2(SCAN_DIV);

   logic [CW-1:0] cnt;

   assign slot_end = run && (cnt == CW'(SCAN_DIV - 1));

   generate
      if (BLANK_CYC > 0) begin : g_blank
         assign show_start = run && (cnt == CW'(BLANK_CYC - 1));
      end else begin : g_no_blank
         assign show_start = 1'b0;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (!run || slot_end) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/display_scan_ctrl.sv
// Six-digit multiplexed display scan with per-slot blanking, blink and leading-zero suppression.
// Latency: all outputs registered; slot 0 starts the cycle after en is seen high in IDLE.
// Backpressure: none; en=0 returns to IDLE on the next edge.
module display_scan_ctrl
   import display_pkg::*;
#(
   parameter int SCAN_DIV  = 50000,
   parameter int BLANK_CYC = 500,
   parameter int BLINK_DIV = 25
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic [23:0] digits_in,
   input  logic [5:0]  blink_mask,
   input  logic        lz_suppress,
   output logic [2:0]  pos,
   output logic [3:0]  num,
   output logic        blank,
   output logic        frame_start
);

   localparam int          FW         = $clog2(BLINK_DIV + 1);
   localparam scan_state_t SLOT_ENTRY = (BLANK_CYC > 0) ? BLANK : SHOW;

   scan_state_t   state;
   logic [23:0]   snap_d;
   logic [5:0]    snap_m;
   logic          snap_lz;
   logic [FW-1:0] frame_cnt;
   logic          blink_phase;

   logic          run, show_start, slot_end;
   logic          new_frame, frame_done, nxt_phase;
   logic [2:0]    nxt_pos;
   logic [3:0]    ent_code, cur_code;

   function automatic logic [3:0] show_code(input logic [23:0] d, input logic [5:0] m,
                                            input logic lz, input logic ph, input logic [2:0] p);
      logic [3:0] nib;
      nib = digit_nibble(d, p);
      if (nib > 4'd9 || (mask_bit(m, p) && ph) || (p == 3'd0 && lz && nib == 4'd0))
         return BLANK_CODE;
      return nib;
   endfunction

   assign run = en && (state != IDLE);

   display_slot_timer #(
      .SCAN_DIV  (SCAN_DIV),
      .BLANK_CYC (BLANK_CYC)
   ) u_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .run        (run),
      .show_start (show_start),
      .slot_end   (slot_end)
   );

   // Values for the slot being entered; a new frame uses live inputs since they are snapshotted now.
   always_comb begin
      nxt_pos    = (pos == 3'(N_DIGITS - 1)) ? 3'd0 : pos + 3'd1;
      new_frame  = (state == IDLE) || (slot_end && pos == 3'(N_DIGITS - 1));
      frame_done = (frame_cnt == FW'(BLINK_DIV - 1));
      nxt_phase  = (state == IDLE) ? 1'b0 : (frame_done ? ~blink_phase : blink_phase);
      ent_code   = new_frame ? show_code(digits_in, blink_mask, lz_suppress, nxt_phase, 3'd0)
                             : show_code(snap_d, snap_m, snap_lz, blink_phase, nxt_pos);
      cur_code   = show_code(snap_d, snap_m, snap_lz, blink_phase, pos);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         pos         <= 3'd0;
         num         <= BLANK_CODE;
         blank       <= 1'b1;
         frame_start <= 1'b0;
         snap_d      <= 24'hFFFFFF;
         snap_m      <= 6'd0;
         snap_lz     <= 1'b0;
         frame_cnt   <= '0;
         blink_phase <= 1'b0;
      end else begin
         frame_start <= 1'b0;
         if (!en) begin
            state       <= IDLE;
            pos         <= 3'd0;
            num         <= BLANK_CODE;
            blank       <= 1'b1;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
         end else if (state == IDLE || slot_end) begin
            state <= SLOT_ENTRY;
            pos   <= new_frame ? 3'd0 : nxt_pos;
            if (new_frame) begin
               snap_d      <= digits_in;
               snap_m      <= blink_mask;
               snap_lz     <= lz_suppress;
               frame_start <= 1'b1;
            end
            if (state != IDLE && new_frame) begin
               frame_cnt   <= frame_done ? '0 : frame_cnt + FW'(1);
               blink_phase <= nxt_phase;
            end
            if (BLANK_CYC > 0) begin
               num   <= BLANK_CODE;
               blank <= 1'b1;
            end else begin
               num   <= ent_code;
               blank <= (ent_code == BLANK_CODE);
            end
         end else if (show_start) begin
            state <= SHOW;
            num   <= cur_code;
            blank <= (cur_code == BLANK_CODE);
         end
      end
   end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: directed scenarios plus random inputs against a time-indexed model.
module tb_display_scan_ctrl;

   localparam int SD    = 8;
   localparam int BC    = 2;
   localparam int BD    = 2;
   localparam int FRAME = 6 * SD;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        en = 1'b0;
   logic [23:0] digits_in = 24'h0;
   logic [5:0]  blink_mask = 6'd0;
   logic        lz_suppress = 1'b0;
   logic [2:0]  pos;
   logic [3:0]  num;
   logic        blank;
   logic        frame_start;

   int total = 0;
   int bad   = 0;

   // Model: t counts cycles since the display started; everything else is derived from it.
   bit          active = 0;
   int          t = 0;
   logic [23:0] s_d = 24'hFFFFFF;
   logic [5:0]  s_m = 6'd0;
   logic        s_lz = 1'b0;
   logic [2:0]  e_pos;
   logic [3:0]  e_num;
   logic        e_blank, e_fs;

   display_scan_ctrl #(
      .SCAN_DIV  (SD),
      .BLANK_CYC (BC),
      .BLINK_DIV (BD)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .digits_in   (digits_in),
      .blink_mask  (blink_mask),
      .lz_suppress (lz_suppress),
      .pos         (pos),
      .num         (num),
      .blank       (blank),
      .frame_start (frame_start)
   );

   always #5 clk = ~clk;

   task automatic take_snapshot();
      s_d  = digits_in;
      s_m  = blink_mask;
      s_lz = lz_suppress;
   endtask

   task automatic model_edge();
      if (!rst_n || !en) begin
         active = 0;
      end else if (!active) begin
         active = 1;
         t = 0;
         take_snapshot();
      end else begin
         t++;
         if (t % FRAME == 0) take_snapshot();
      end
   endtask

   task automatic model_expect();
      int slot, k, phase;
      logic [3:0] nib;
      if (!active) begin
         e_pos = 3'd0; e_num = 4'hF; e_blank = 1'b1; e_fs = 1'b0;
      end else begin
         slot  = (t / SD) % 6;
         k     = t % SD;
         phase = ((t / FRAME) / BD) % 2;
         e_pos = 3'(slot);
         e_fs  = (t % FRAME == 0);
         if (k < BC) begin
            e_num = 4'hF;
         end else begin
            nib = 4'((s_d >> (4 * (5 - slot))) & 24'hF);
            if (nib > 4'd9 || (s_m[5 - slot] && phase == 1) || (slot == 0 && s_lz && nib == 4'd0))
               e_num = 4'hF;
            else
               e_num = nib;
         end
         e_blank = (k < BC) || (e_num == 4'hF);
      end
   endtask

   task automatic check(input string tag);
      model_expect();
      total++;
      assert ({pos, num, blank, frame_start} === {e_pos, e_num, e_blank, e_fs}) else begin
         bad++;
         $error("FAIL %s t=%0d: pos/num/blank/fs got %0d/%h/%b/%b want %0d/%h/%b/%b",
                tag, t, pos, num, blank, frame_start, e_pos, e_num, e_blank, e_fs);
      end
   endtask

   task automatic cyc(input string tag);
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check(tag);
   endtask

   task automatic run_until(input int slot, input int k, input string tag);
      for (int n = 0; n < 2 * FRAME; n++) begin
         if (active && (t / SD) % 6 == slot && t % SD == k) return;
         cyc(tag);
      end
      total++;
      assert (active && (t / SD) % 6 == slot && t % SD == k) else begin
         bad++;
         $error("FAIL %s: slot %0d cycle %0d not reached, t=%0d", tag, slot, k, t);
      end
   endtask

   initial begin
      // Reset asserted between edges must act without waiting for a clock.
      #2 rst_n = 1'b0;
      #1 check("reset_async");
      repeat (2) cyc("reset_hold");
      rst_n = 1'b1;
      cyc("idle");

      // Basic scan of 123456.
      digits_in = 24'h123456;
      en = 1'b1;
      repeat (2 * FRAME) cyc("t1_scan");

      // Mid-frame change must not tear the current frame.
      run_until(3, BC, "t2_seek");
      digits_in = 24'h999999;
      repeat (FRAME + SD) cyc("t2_notear");

      // Blink of digits 2 and 3 over several blink half-periods.
      digits_in  = 24'h123456;
      blink_mask = 6'b001100;
      repeat (5 * FRAME) cyc("t3_blink");

      // Leading-zero suppression and non-BCD nibble.
      blink_mask  = 6'd0;
      digits_in   = 24'h0A3059;
      lz_suppress = 1'b1;
      repeat (2 * FRAME) cyc("t4_lz");

      // Drop enable mid-SHOW at pos 4, then restart.
      run_until(4, SD - 3, "t5_seek");
      en = 1'b0;
      cyc("t5_drop");
      cyc("t5_idle");
      en = 1'b1;
      repeat (FRAME + 4) cyc("t5_restart");

      // Asynchronous reset in the middle of a slot.
      run_until(2, BC + 1, "t6_seek");
      #2 rst_n = 1'b0;
      active = 0;
      #1 check("t6_async");
      cyc("t6_hold");
      rst_n = 1'b1;
      repeat (SD + 2) cyc("t6_resume");

      // Random inputs, including mid-frame changes and enable drops.
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 15) == 0) digits_in = 24'($urandom);
         if ($urandom_range(0, 63) == 0) blink_mask = 6'($urandom);
         if ($urandom_range(0, 63) == 0) lz_suppress = ~lz_suppress;
         en = en ? ($urandom_range(0, 299) != 0) : ($urandom_range(0, 9) == 0);
         cyc("rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
